// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one DW-bit ALU between two requesters:
//   req0 is the core decode stage.
//   req1 is a helper engine, for example a PARCMP/MNABS scan loop.
//
// Pipeline, one operation per cycle:
//   - Stage 1 (issue register) drives the ALU operand/opcode outputs.
//   - Stage 2 (response register) captures the ALU result for the requester
//     that issued. Accept at edge T, rspN_valid_o high in the cycle after T+1.
//
// Arbitration (default build):
//   - Fixed priority to req0.
//   - A starvation counter forces a req1 grant once req1 has waited
//     STARVE_LIMIT consecutive eligible cycles.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   When defined, fixed priority and the starvation counter are replaced by
//   a 1-bit round-robin pointer that favours req0 out of reset.
//
// Carry and HALT state:
//   - Each requester owns a private carry flag, fed to the ALU overflow input
//     while that requester's op is in the issue stage. It is updated from the
//     ALU overflow output for ADD and SLL only.
//   - A requester that issues HALT is locked out (ready low) until reset.
//
// Ports:
//   clk_i, reset_i                  clock, synchronous active-high reset
//   reqN_valid_i / reqN_ready_o     request handshake (ready = combinational grant)
//   reqN_op_i, reqN_rs_i, reqN_rt_i,
//   reqN_cpsr_i, reqN_cnt_i         request opcode and operands
//   rspN_valid_o                    one-cycle result strobe
//   rspN_result_o, rspN_branch_o    captured ALU result/branch, held between strobes
//   haltN_o                         requester N has issued HALT
//   alu_op_o, alu_rs_o, alu_rt_o,
//   alu_cpsr_o, alu_cnt_o, alu_ovf_o  to the ALU (all zero when no op is issued)
//   alu_result_i, alu_branch_i,
//   alu_ovf_i                       from the ALU
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int DW           = 8,
  parameter int OPW          = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk_i,
  input  logic           reset_i,

  input  logic           req0_valid_i,
  output logic           req0_ready_o,
  input  logic [OPW-1:0] req0_op_i,
  input  logic [DW-1:0]  req0_rs_i,
  input  logic [DW-1:0]  req0_rt_i,
  input  logic [DW-1:0]  req0_cpsr_i,
  input  logic [DW-1:0]  req0_cnt_i,

  input  logic           req1_valid_i,
  output logic           req1_ready_o,
  input  logic [OPW-1:0] req1_op_i,
  input  logic [DW-1:0]  req1_rs_i,
  input  logic [DW-1:0]  req1_rt_i,
  input  logic [DW-1:0]  req1_cpsr_i,
  input  logic [DW-1:0]  req1_cnt_i,

  output logic           rsp0_valid_o,
  output logic [DW:0]    rsp0_result_o,
  output logic           rsp0_branch_o,
  output logic           rsp1_valid_o,
  output logic [DW:0]    rsp1_result_o,
  output logic           rsp1_branch_o,

  output logic           halt0_o,
  output logic           halt1_o,

  output logic [OPW-1:0] alu_op_o,
  output logic [DW-1:0]  alu_rs_o,
  output logic [DW-1:0]  alu_rt_o,
  output logic [DW-1:0]  alu_cpsr_o,
  output logic [DW-1:0]  alu_cnt_o,
  output logic           alu_ovf_o,
  input  logic [DW:0]    alu_result_i,
  input  logic           alu_branch_i,
  input  logic           alu_ovf_i
);

  localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
  localparam logic [OPW-1:0] OP_SLL  = OPW'(5);
  localparam logic [OPW-1:0] OP_HALT = OPW'(12);

  logic [1:0]     req_valid;
  logic [1:0]     elig;
  logic [1:0]     grant;
  logic [1:0]     halt_vec;
  logic [1:0]     carry_vec;
  logic           xfer;
  logic           xfer_id;

  logic [OPW-1:0] sel_op;
  logic [DW-1:0]  sel_rs;
  logic [DW-1:0]  sel_rt;
  logic [DW-1:0]  sel_cpsr;
  logic [DW-1:0]  sel_cnt;

  logic           iss_valid_reg;
  logic           iss_id_reg;
  logic [OPW-1:0] iss_op_reg;
  logic [DW-1:0]  iss_rs_reg;
  logic [DW-1:0]  iss_rt_reg;
  logic [DW-1:0]  iss_cpsr_reg;
  logic [DW-1:0]  iss_cnt_reg;

  assign req_valid = {req1_valid_i, req0_valid_i};

  // ---------------------------------------------------------------------------
  // Grant
  // ---------------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
  // Pointer names the requester preferred on the next contended cycle.
  logic rr_ptr_reg;

  always_comb begin
    grant = 2'b00;
    if (elig[0] && elig[1]) begin
      grant = rr_ptr_reg ? 2'b10 : 2'b01;
    end else if (elig[0]) begin
      grant = 2'b01;
    end else if (elig[1]) begin
      grant = 2'b10;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr_reg <= 1'b0;
    end else if (xfer) begin
      rr_ptr_reg <= ~xfer_id;
    end
  end
`else
  localparam int             SW         = 4;
  localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt_reg;

  always_comb begin
    grant = 2'b00;
    if ((starve_cnt_reg == STARVE_MAX) && elig[1]) begin
      grant = 2'b10;
    end else if (elig[0]) begin
      grant = 2'b01;
    end else if (elig[1]) begin
      grant = 2'b10;
    end
  end

  // Counts consecutive cycles req1 is eligible but loses arbitration.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      starve_cnt_reg <= '0;
    end else if (elig[1] && !grant[1]) begin
      if (starve_cnt_reg != STARVE_MAX) begin
        starve_cnt_reg <= starve_cnt_reg + 1'b1;
      end
    end else begin
      starve_cnt_reg <= '0;
    end
  end
`endif

  assign xfer         = |grant;
  assign xfer_id      = grant[1];
  assign req0_ready_o = grant[0];
  assign req1_ready_o = grant[1];

  assign sel_op   = xfer_id ? req1_op_i   : req0_op_i;
  assign sel_rs   = xfer_id ? req1_rs_i   : req0_rs_i;
  assign sel_rt   = xfer_id ? req1_rt_i   : req0_rt_i;
  assign sel_cpsr = xfer_id ? req1_cpsr_i : req0_cpsr_i;
  assign sel_cnt  = xfer_id ? req1_cnt_i  : req0_cnt_i;

  // ---------------------------------------------------------------------------
  // Issue stage. Fields are zeroed on idle cycles so the ALU sees SMA with
  // zero operands whenever nothing is issued.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i || !xfer) begin
      iss_valid_reg <= 1'b0;
      iss_id_reg    <= 1'b0;
      iss_op_reg    <= '0;
      iss_rs_reg    <= '0;
      iss_rt_reg    <= '0;
      iss_cpsr_reg  <= '0;
      iss_cnt_reg   <= '0;
    end else begin
      iss_valid_reg <= 1'b1;
      iss_id_reg    <= xfer_id;
      iss_op_reg    <= sel_op;
      iss_rs_reg    <= sel_rs;
      iss_rt_reg    <= sel_rt;
      iss_cpsr_reg  <= sel_cpsr;
      iss_cnt_reg   <= sel_cnt;
    end
  end

  assign alu_op_o   = iss_op_reg;
  assign alu_rs_o   = iss_rs_reg;
  assign alu_rt_o   = iss_rt_reg;
  assign alu_cpsr_o = iss_cpsr_reg;
  assign alu_cnt_o  = iss_cnt_reg;
  // Carry is read live from the flag, so an ADD issued right behind another
  // ADD from the same requester sees the carry written at the same edge.
  assign alu_ovf_o  = iss_valid_reg & carry_vec[iss_id_reg];

  // ---------------------------------------------------------------------------
  // Per-requester state: halt lock, carry flag, response register
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_req
      localparam logic ID = 1'(gi);

      logic          halt_reg;
      logic          carry_reg;
      logic          rsp_valid_reg;
      logic [DW:0]   rsp_result_reg;
      logic          rsp_branch_reg;
      logic          iss_hit;
      logic          carry_op;

      assign iss_hit       = iss_valid_reg && (iss_id_reg == ID);
      assign carry_op      = (iss_op_reg == OP_ADD) || (iss_op_reg == OP_SLL);
      assign elig[gi]      = req_valid[gi] & ~halt_reg;
      assign halt_vec[gi]  = halt_reg;
      assign carry_vec[gi] = carry_reg;

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          halt_reg       <= 1'b0;
          carry_reg      <= 1'b0;
          rsp_valid_reg  <= 1'b0;
          rsp_result_reg <= '0;
          rsp_branch_reg <= 1'b0;
        end else begin
          if (grant[gi] && (sel_op == OP_HALT)) begin
            halt_reg <= 1'b1;
          end
          rsp_valid_reg <= iss_hit;
          if (iss_hit) begin
            rsp_result_reg <= alu_result_i;
            rsp_branch_reg <= alu_branch_i;
            if (carry_op) begin
              carry_reg <= alu_ovf_i;
            end
          end
        end
      end
    end
  endgenerate

  assign halt0_o       = halt_vec[0];
  assign halt1_o       = halt_vec[1];
  assign rsp0_valid_o  = gen_req[0].rsp_valid_reg;
  assign rsp0_result_o = gen_req[0].rsp_result_reg;
  assign rsp0_branch_o = gen_req[0].rsp_branch_reg;
  assign rsp1_valid_o  = gen_req[1].rsp_valid_reg;
  assign rsp1_result_o = gen_req[1].rsp_result_reg;
  assign rsp1_branch_o = gen_req[1].rsp_branch_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed bench for alu_arbiter (default build, STARVE_LIMIT = 4).
//
// A small behavioural ALU closes the loop:
//   ADD  = 8-bit sum with carry-in/out; the carry is reported on overflow.
//   SLL  = shift left one bit through carry.
//   CMP  = cpsr with bit5 = rs>rt and bit4 = rs!=rt.
//   BR   = branch on cpsr bit5.
//   HALT = 0.
//   Any other op = rs ^ rt ^ cnt.
//
// Each table row is one clock cycle:
//   - Inputs are driven at the falling edge.
//   - Ready, alu_ovf_o and the response outputs are checked 1 ns later.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_op, req1_op;
  logic [7:0] req0_rs, req0_rt, req0_cpsr, req0_cnt;
  logic [7:0] req1_rs, req1_rt, req1_cpsr, req1_cnt;
  logic       rsp0_valid, rsp0_branch, rsp1_valid, rsp1_branch;
  logic [8:0] rsp0_result, rsp1_result;
  logic       halt0, halt1;
  logic [3:0] alu_op;
  logic [7:0] alu_rs, alu_rt, alu_cpsr, alu_cnt;
  logic       alu_ovf_out, alu_branch, alu_ovf_in;
  logic [8:0] alu_result;
  logic [8:0] sum9;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DW(8), .OPW(4), .STARVE_LIMIT(4)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .req0_valid_i (req0_valid),
    .req0_ready_o (req0_ready),
    .req0_op_i    (req0_op),
    .req0_rs_i    (req0_rs),
    .req0_rt_i    (req0_rt),
    .req0_cpsr_i  (req0_cpsr),
    .req0_cnt_i   (req0_cnt),
    .req1_valid_i (req1_valid),
    .req1_ready_o (req1_ready),
    .req1_op_i    (req1_op),
    .req1_rs_i    (req1_rs),
    .req1_rt_i    (req1_rt),
    .req1_cpsr_i  (req1_cpsr),
    .req1_cnt_i   (req1_cnt),
    .rsp0_valid_o (rsp0_valid),
    .rsp0_result_o(rsp0_result),
    .rsp0_branch_o(rsp0_branch),
    .rsp1_valid_o (rsp1_valid),
    .rsp1_result_o(rsp1_result),
    .rsp1_branch_o(rsp1_branch),
    .halt0_o      (halt0),
    .halt1_o      (halt1),
    .alu_op_o     (alu_op),
    .alu_rs_o     (alu_rs),
    .alu_rt_o     (alu_rt),
    .alu_cpsr_o   (alu_cpsr),
    .alu_cnt_o    (alu_cnt),
    .alu_ovf_o    (alu_ovf_out),
    .alu_result_i (alu_result),
    .alu_branch_i (alu_branch),
    .alu_ovf_i    (alu_ovf_in)
  );

  // Behavioural ALU
  always_comb begin
    alu_result = '0;
    alu_branch = 1'b0;
    alu_ovf_in = 1'b0;
    sum9       = '0;
    case (alu_op)
      4'd3: begin
        sum9       = {1'b0, alu_rs} + {1'b0, alu_rt} + {8'd0, alu_ovf_out};
        alu_result = {1'b0, sum9[7:0]};
        alu_ovf_in = sum9[8];
      end
      4'd5: begin
        alu_result = {1'b0, alu_rs[6:0], alu_ovf_out};
        alu_ovf_in = alu_rs[7];
      end
      4'd6: alu_result = {1'b0, alu_cpsr[7:6], (alu_rs > alu_rt), (alu_rs != alu_rt), alu_cpsr[3:0]};
      4'd7: alu_branch = alu_cpsr[5];
      4'd12: alu_result = '0;
      default: alu_result = {1'b0, alu_rs ^ alu_rt ^ alu_cnt};
    endcase
  end

  typedef struct packed {
    logic       v0;
    logic [3:0] op0;
    logic [7:0] rs0;
    logic [7:0] rt0;
    logic [7:0] c0;
    logic       v1;
    logic [3:0] op1;
    logic [7:0] rs1;
    logic [7:0] rt1;
    logic [7:0] c1;
    logic       g0;
    logic       g1;
    logic       ovf;
    logic       r0v;
    logic [8:0] r0;
    logic       r1v;
    logic [8:0] r1;
    logic       b1;
  } vec_t;

  localparam int NROWS = 26;
  vec_t tbl [NROWS];

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic [3:0] op0, input logic [7:0] rs0, input logic [7:0] rt0,
                       input logic v1, input logic [3:0] op1, input logic [7:0] rs1);
    req0_valid = v0; req0_op = op0; req0_rs = rs0; req0_rt = rt0; req0_cpsr = 8'h00;
    req1_valid = v1; req1_op = op1; req1_rs = rs1; req1_rt = 8'h00; req1_cpsr = 8'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- vector table ----------------
    for (int k = 0; k < NROWS; k++) tbl[k] = '0;
    //             v0   op0   rs0    rt0    c0     v1   op1   rs1    rt1    c1     g0   g1   ovf  r0v  r0       r1v  r1       b1
    tbl[0]  = '{1'b1,4'd3,8'h80,8'h80,8'h00, 1'b0,4'd0,8'h00,8'h00,8'h00, 1'b1,1'b0,1'b0, 1'b0,9'h000, 1'b0,9'h000,1'b0};
    tbl[1]  = '{1'b1,4'd3,8'h01,8'h01,8'h00, 1'b0,4'd0,8'h00,8'h00,8'h00, 1'b1,1'b0,1'b0, 1'b0,9'h000, 1'b0,9'h000,1'b0};
    tbl[2]  = '{1'b0,4'd0,8'h00,8'h00,8'h00, 1'b0,4'd0,8'h00,8'h00,8'h00, 1'b0,1'b0,1'b1, 1'b1,9'h000, 1'b0,9'h000,1'b0};
    tbl[3]  = '{1'b1,4'd3,8'hFF,8'h01,8'h00, 1'b0,4'd0,8'h00,8'h00,8'h00, 1'b1,1'b0,1'b0, 1'b1,9'h003, 1'b0,9'h000,1'b0};
    tbl[4]  = '{1'b0,4'd0,8'h00,8'h00,8'h00, 1'b1,4'd3,8'h01,8'h01,8'h00, 1'b0,1'b1,1'b0, 1'b0,9'h000, 1'b0,9'h000,1'b0};
    tbl[5]  = '{1'b1,4'd3,8'h00,8'h00,8'h00, 1'b0,4'd0,8'h00,8'h00,8'h00, 1'b1,1'b0,1'b0, 1'b1,9'h000, 1'b0,9'h000,1'b0};
    tbl[6]  = '{1'b0,4'd0,8'h00,8'h00,8'h00, 1'b0,4'd0,8'h00,8'h00,8'h00, 1'b0,1'b0,1'b1, 1'b0,9'h000, 1'b1,9'h002,1'b0};
    tbl[7]  = '{1'b0,4'd0,8'h00,8'h00,8'h00, 1'b1,4'd3,8'h00,8'h00,8'h00, 1'b0,1'b1,1'b0, 1'b1,9'h001, 1'b0,9'h000,1'b0};
    tbl[8]  = '{1'b0,4'd0,8'h00,8'h00,8'h00, 1'b0,4'd0,8'h00,8'h00,8'h00, 1'b0,1'b0,1'b0, 1'b0,9'h000, 1'b0,9'h000,1'b0};
    tbl[9]  = '{1'b0,4'd0,8'h00,8'h00,8'h00, 1'b0,4'd0,8'h00,8'h00,8'h00, 1'b0,1'b0,1'b0, 1'b0,9'h000, 1'b1,9'h000,1'b0};
    tbl[10] = '{1'b0,4'd0,8'h00,8'h00,8'h00, 1'b1,4'd6,8'h05,8'h03,8'h02, 1'b0,1'b1,1'b0, 1'b0,9'h000, 1'b0,9'h000,1'b0};
    tbl[11] = '{1'b0,4'd0,8'h00,8'h00,8'h00, 1'b1,4'd7,8'h00,8'h00,8'h32, 1'b0,1'b1,1'b0, 1'b0,9'h000, 1'b0,9'h000,1'b0};
    tbl[12] = '{1'b0,4'd0,8'h00,8'h00,8'h00, 1'b0,4'd0,8'h00,8'h00,8'h00, 1'b0,1'b0,1'b0, 1'b0,9'h000, 1'b1,9'h032,1'b0};
    tbl[13] = '{1'b0,4'd0,8'h00,8'h00,8'h00, 1'b0,4'd0,8'h00,8'h00,8'h00, 1'b0,1'b0,1'b0, 1'b0,9'h000, 1'b1,9'h000,1'b1};
    // Starvation: both requesters valid for 10 cycles; every fifth grant is req1.
    for (int i = 0; i < 10; i++) begin
      tbl[14+i].v0  = 1'b1;
      tbl[14+i].op0 = 4'd1;
      tbl[14+i].rs0 = 8'(8'h40 + i);
      tbl[14+i].v1  = 1'b1;
      tbl[14+i].op1 = 4'd1;
      tbl[14+i].rs1 = 8'(8'h80 + i);
      tbl[14+i].g0  = ((i % 5) != 4);
      tbl[14+i].g1  = ((i % 5) == 4);
      if ((i % 5) == 4) begin
        tbl[16+i].r1v = 1'b1;
        tbl[16+i].r1  = 9'(9'h080 + i);
      end else begin
        tbl[16+i].r0v = 1'b1;
        tbl[16+i].r0  = 9'(9'h040 + i);
      end
    end

    // ---------------- reset ----------------
    reset_i = 1'b1;
    req0_cnt = 8'h00;
    req1_cnt = 8'h00;
    drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 4'd0, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp0_valid", {8'd0, rsp0_valid}, 9'd0);
    chk("reset_rsp1_valid", {8'd0, rsp1_valid}, 9'd0);
    chk("reset_halt0", {8'd0, halt0}, 9'd0);
    chk("reset_alu_op", {5'd0, alu_op}, 9'd0);
    chk("reset_alu_ovf", {8'd0, alu_ovf_out}, 9'd0);
    reset_i = 1'b0;

    // ---------------- table ----------------
    for (int k = 0; k < NROWS; k++) begin
      if (k != 0) @(negedge clk);
      req0_valid = tbl[k].v0; req0_op = tbl[k].op0; req0_rs = tbl[k].rs0;
      req0_rt = tbl[k].rt0; req0_cpsr = tbl[k].c0;
      req1_valid = tbl[k].v1; req1_op = tbl[k].op1; req1_rs = tbl[k].rs1;
      req1_rt = tbl[k].rt1; req1_cpsr = tbl[k].c1;
      #1;
      $display("row %0d: g0=%0b g1=%0b ovf=%0b rsp0=%0b/%03h rsp1=%0b/%03h br1=%0b",
               k, req0_ready, req1_ready, alu_ovf_out, rsp0_valid, rsp0_result,
               rsp1_valid, rsp1_result, rsp1_branch);
      chk($sformatf("row%0d_ready0", k), {8'd0, req0_ready}, {8'd0, tbl[k].g0});
      chk($sformatf("row%0d_ready1", k), {8'd0, req1_ready}, {8'd0, tbl[k].g1});
      chk($sformatf("row%0d_alu_ovf", k), {8'd0, alu_ovf_out}, {8'd0, tbl[k].ovf});
      chk($sformatf("row%0d_rsp0_valid", k), {8'd0, rsp0_valid}, {8'd0, tbl[k].r0v});
      chk($sformatf("row%0d_rsp1_valid", k), {8'd0, rsp1_valid}, {8'd0, tbl[k].r1v});
      if (tbl[k].r0v) chk($sformatf("row%0d_rsp0_result", k), rsp0_result, tbl[k].r0);
      if (tbl[k].r1v) begin
        chk($sformatf("row%0d_rsp1_result", k), rsp1_result, tbl[k].r1);
        chk($sformatf("row%0d_rsp1_branch", k), {8'd0, rsp1_branch}, {8'd0, tbl[k].b1});
      end
    end

    // ---------------- HALT on req0, req1 keeps streaming ----------------
    @(negedge clk); drive(1'b1, 4'd12, 8'h00, 8'h00, 1'b1, 4'd1, 8'h11); #1;
    $display("halt A: ready0=%0b ready1=%0b", req0_ready, req1_ready);
    chk("haltA_ready0", {8'd0, req0_ready}, 9'd1);
    chk("haltA_ready1", {8'd0, req1_ready}, 9'd0);
    @(negedge clk); drive(1'b1, 4'd1, 8'h22, 8'h00, 1'b1, 4'd1, 8'h12); #1;
    $display("halt B: halt0=%0b ready0=%0b ready1=%0b", halt0, req0_ready, req1_ready);
    chk("haltB_halt0", {8'd0, halt0}, 9'd1);
    chk("haltB_halt1", {8'd0, halt1}, 9'd0);
    chk("haltB_ready0", {8'd0, req0_ready}, 9'd0);
    chk("haltB_ready1", {8'd0, req1_ready}, 9'd1);
    @(negedge clk); drive(1'b1, 4'd1, 8'h23, 8'h00, 1'b1, 4'd1, 8'h13); #1;
    $display("halt C: rsp0=%0b/%03h ready0=%0b", rsp0_valid, rsp0_result, req0_ready);
    chk("haltC_rsp0_valid", {8'd0, rsp0_valid}, 9'd1);
    chk("haltC_rsp0_result", rsp0_result, 9'h000);
    chk("haltC_ready0", {8'd0, req0_ready}, 9'd0);
    chk("haltC_ready1", {8'd0, req1_ready}, 9'd1);
    @(negedge clk); drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd1, 8'h14); #1;
    $display("halt D: rsp1=%0b/%03h", rsp1_valid, rsp1_result);
    chk("haltD_rsp1_valid", {8'd0, rsp1_valid}, 9'd1);
    chk("haltD_rsp1_result", rsp1_result, 9'h012);
    chk("haltD_rsp0_valid", {8'd0, rsp0_valid}, 9'd0);
    @(negedge clk); drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 4'd0, 8'h00); #1;
    $display("halt E: rsp1=%0b/%03h", rsp1_valid, rsp1_result);
    chk("haltE_rsp1_valid", {8'd0, rsp1_valid}, 9'd1);
    chk("haltE_rsp1_result", rsp1_result, 9'h013);
    @(negedge clk); #1;
    $display("halt F: rsp1=%0b/%03h", rsp1_valid, rsp1_result);
    chk("haltF_rsp1_valid", {8'd0, rsp1_valid}, 9'd1);
    chk("haltF_rsp1_result", rsp1_result, 9'h014);
    @(negedge clk); #1;
    $display("halt G: rsp1=%0b/%03h", rsp1_valid, rsp1_result);
    chk("haltG_rsp1_valid", {8'd0, rsp1_valid}, 9'd0);
    chk("haltG_rsp1_hold", rsp1_result, 9'h014);

    // ---------------- reset mid-flight ----------------
    @(negedge clk); reset_i = 1'b1;
    @(negedge clk); reset_i = 1'b0; drive(1'b1, 4'd3, 8'hFF, 8'h01, 1'b0, 4'd0, 8'h00); #1;
    $display("rst R1: halt0=%0b ready0=%0b", halt0, req0_ready);
    chk("rst1_halt0", {8'd0, halt0}, 9'd0);
    chk("rst1_ready0", {8'd0, req0_ready}, 9'd1);
    @(negedge clk); drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 4'd0, 8'h00);
    @(negedge clk); drive(1'b1, 4'd1, 8'h55, 8'h00, 1'b0, 4'd0, 8'h00); #1;
    chk("rst3_ready0", {8'd0, req0_ready}, 9'd1);
    @(negedge clk); reset_i = 1'b1; drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 4'd0, 8'h00);
    @(negedge clk); reset_i = 1'b0; drive(1'b1, 4'd3, 8'h00, 8'h00, 1'b0, 4'd0, 8'h00); #1;
    $display("rst R5: rsp0=%0b alu_op=%0d rsp1_result=%03h", rsp0_valid, alu_op, rsp1_result);
    chk("rst5_rsp0_valid", {8'd0, rsp0_valid}, 9'd0);
    chk("rst5_halt0", {8'd0, halt0}, 9'd0);
    chk("rst5_alu_op", {5'd0, alu_op}, 9'd0);
    chk("rst5_alu_rs", {1'b0, alu_rs}, 9'd0);
    chk("rst5_rsp1_result", rsp1_result, 9'd0);
    chk("rst5_ready0", {8'd0, req0_ready}, 9'd1);
    @(negedge clk); drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 4'd0, 8'h00); #1;
    $display("rst R6: rsp0=%0b alu_op=%0d ovf=%0b", rsp0_valid, alu_op, alu_ovf_out);
    chk("rst6_rsp0_valid", {8'd0, rsp0_valid}, 9'd0);
    chk("rst6_alu_op", {5'd0, alu_op}, 9'd3);
    chk("rst6_carry0_cleared", {8'd0, alu_ovf_out}, 9'd0);
    @(negedge clk); #1;
    $display("rst R7: rsp0=%0b/%03h", rsp0_valid, rsp0_result);
    chk("rst7_rsp0_valid", {8'd0, rsp0_valid}, 9'd1);
    chk("rst7_rsp0_result", rsp0_result, 9'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 8-bit ALU between two requesters: req0 (core decode stage) and req1 (helper engine, e.g. a PARCMP/MNABS scan loop).
- Fixed priority to req0, with a starvation counter that forces a req1 grant.
- Two-stage pipeline:
  - Stage 1: issue register drives the ALU.
  - Stage 2: response register captures the ALU result.
- Keeps a per-requester carry flag that feeds the ALU overflow_i input, so ADD/SLL carry chains stay private to each requester.

Parameters:
- DW, 8: operand width. The ALU result is DW+1 bits.
- OPW, 4: opcode width.
- STARVE_LIMIT, 4: consecutive cycles req1 may wait while valid before its grant is forced. Legal range 1..15.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- reqN_valid_i  in  1  request valid (N = 0, 1)
- reqN_ready_o  out  1  request accepted this cycle (combinational grant)
- reqN_op_i  in  OPW  opcode (SMA=0 … ADD=3, SLL=5, HALT=12, PARCMP=14, MNABS=15)
- reqN_rs_i, reqN_rt_i  in  DW  operands
- reqN_cpsr_i, reqN_cnt_i  in  DW  status and counter operands
- rspN_valid_o  out  1  one-cycle result strobe
- rspN_result_o  out  DW+1  captured ALU result
- rspN_branch_o  out  1  captured ALU branch
- haltN_o  out  1  requester N has issued HALT
- alu_op_o  out  OPW  to ALU op_i
- alu_rs_o, alu_rt_o, alu_cpsr_o, alu_cnt_o  out  DW  to ALU
- alu_ovf_o  out  1  to ALU overflow_i (carry flag of the issuing requester)
- alu_result_i  in  DW+1  from ALU
- alu_branch_i  in  1  from ALU
- alu_ovf_i  in  1  from ALU overflow_o

Behaviour:
- Reset (sync, active-high) clears:
  - issue valid, response valid, carry0, carry1, halt0, halt1, starve counter, RR pointer;
  - all outputs to 0, with alu_op_o = 0 (SMA).
  - Reset asserted mid-operation discards the in-flight issue and response; no rsp strobe follows.
- Eligibility: reqN eligible = reqN_valid_i & ~haltN.
- Grant, combinational, at most one per cycle:
  - If starve_cnt == STARVE_LIMIT and req1 eligible: grant req1.
  - Else if req0 eligible: grant req0.
  - Else if req1 eligible: grant req1.
  - reqN_ready_o equals grantN. A transfer is valid & ready.
- Starve counter:
  - Increments when req1 is eligible and not granted, saturating at STARVE_LIMIT.
  - Clears on a req1 grant, or when req1 is not eligible.
- Issue stage, on the edge where a transfer occurs:
  - Latch op, rs, rt, cpsr, cnt and requester id.
  - Set issue_valid; otherwise clear issue_valid.
- ALU outputs are driven from the issue register:
  - When issue_valid = 0, alu_op_o = 0 and all operands are 0.
  - alu_ovf_o = carry of the issuing requester.
- Response stage, on the edge after issue:
  - Capture alu_result_i and alu_branch_i into rspN for the issuing id.
  - Pulse rspN_valid_o for exactly one cycle.
  - Latency is 2 cycles: accept at edge T, rsp valid in the cycle after edge T+1.
  - Throughput is 1 operation per cycle.
  - rspN_result_o and rspN_branch_o hold their value until the next rspN strobe.
- Carry flags:
  - At the response edge, carryN <= alu_ovf_i only if the op is ADD (3) or SLL (5); otherwise hold.
  - Back-to-back ADDs from the same requester see the updated carry with no stall. The flag updates at the edge T+1, and the next issue reads it during T+2.
- HALT (12):
  - When accepted, set haltN at the accept edge. reqN_ready_o stays 0 until reset.
  - HALT still flows through the pipeline and produces an rsp strobe with result 0.
  - The other requester is unaffected.
- No backpressure on responses; requesters must accept rsp strobes.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined:
  - Fixed priority and the starve counter are replaced by a 1-bit round-robin pointer.
  - When both requesters are eligible, grant the one not granted last.
  - The pointer updates on every transfer and resets to favour req0.
- ARB_ROUND_ROBIN_EN undefined: fixed-priority-plus-starvation behaviour exactly as above.

Test Plan:
- Single ADD: req0 issues ADD rs=0x80, rt=0x80, carry0=0 → rsp0_valid 2 cycles after accept, result=0x000, carry0=1. A following ADD 0x01+0x01 → result=0x003.
- Carry isolation: req0 ADD 0xFF+0x01 (carry0=1), then req1 ADD 0x01+0x01 → rsp1 result=0x002, carry1=0, carry0 still 1.
- Starvation: both valid continuously with STARVE_LIMIT=4 → grant pattern 0,0,0,0,1,0,0,0,0,1; each req1 result arrives 2 cycles after its grant.
- HALT: req0 HALT accepted → halt0_o=1 next cycle, req0_ready_o=0 thereafter, rsp0 strobe with result 0. req1 continues at 1 operation per cycle.
- CMP/BR passthrough: req1 CMP rs=5, rt=3, cpsr=0x02 → rsp1 result=0x032. Then BR with cpsr=0x32 → rsp1_branch_o=1.
- Reset mid-flight: assert reset_i the cycle after accept → no rsp strobe; all flags, halts and outputs read 0 the next cycle.
